// File: rtl/cache_ctrl_wb.sv
// Direct-mapped write-back, write-allocate cache controller.
// Sits between the CPU load/store port and a level/ack memory port.
module cache_ctrl_wb #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 64,
    parameter int INDEX_W = 8,
    parameter int CNT_W   = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rd_en,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [DATA_W/8-1:0] wr_be,
    output logic [DATA_W-1:0]   rd_data,
    output logic                rd_valid,
    output logic                wr_done,
    output logic                hit,
    output logic                stall,
    output logic                mem_rd_en,
    output logic                mem_wr_en,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wr_data,
    input  logic [DATA_W-1:0]   mem_rd_data,
    input  logic                mem_ack,
    output logic [CNT_W-1:0]    hit_cnt,
    output logic [CNT_W-1:0]    miss_cnt
);

    localparam int BE_W      = DATA_W / 8;
    localparam int OFFSET_W  = $clog2(BE_W);
    localparam int NUM_LINES = 2 ** INDEX_W;
    localparam int TAG_W     = ADDR_W - INDEX_W - OFFSET_W;

    typedef enum logic [2:0] {
        IDLE,
        COMPARE,
        WRITEBACK,
        FILL,
        DONE
    } state_t;

    state_t state, state_n;

    logic [TAG_W-1:0]  tag_arr  [NUM_LINES];
    logic [DATA_W-1:0] data_arr [NUM_LINES];
    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] dirty_q;

    logic               req_rd;
    logic [TAG_W-1:0]   req_tag;
    logic [INDEX_W-1:0] req_index;
    logic [DATA_W-1:0]  req_wdata;
    logic [BE_W-1:0]    req_be;

    logic [TAG_W-1:0]  line_tag;
    logic [DATA_W-1:0] line_data;
    logic              line_valid;
    logic              line_dirty;
    logic              line_hit;

    logic unused_offset;
    assign unused_offset = ^addr[OFFSET_W-1:0];

    function automatic logic [DATA_W-1:0] merge_be(
        input logic [DATA_W-1:0] base,
        input logic [DATA_W-1:0] wdat,
        input logic [BE_W-1:0]   be
    );
        logic [DATA_W-1:0] r;
        r = base;
        for (int i = 0; i < BE_W; i++) begin
            if (be[i]) begin
                r[8*i +: 8] = wdat[8*i +: 8];
            end
        end
        return r;
    endfunction

    assign line_tag   = tag_arr[req_index];
    assign line_data  = data_arr[req_index];
    assign line_valid = valid_q[req_index];
    assign line_dirty = dirty_q[req_index];
    assign line_hit   = line_valid && (line_tag == req_tag);

    always_comb begin
        state_n     = state;
        stall       = 1'b0;
        hit         = 1'b0;
        rd_valid    = 1'b0;
        wr_done     = 1'b0;
        mem_rd_en   = 1'b0;
        mem_wr_en   = 1'b0;
        mem_addr    = '0;
        mem_wr_data = '0;
        unique case (state)
            IDLE: begin
                if (rd_en || wr_en) begin
                    state_n = COMPARE;
                end
            end
            COMPARE: begin
                stall = 1'b1;
                hit   = line_hit;
                if (line_hit) begin
                    state_n = DONE;
                end else if (line_valid && line_dirty) begin
                    state_n = WRITEBACK;
                end else begin
                    state_n = FILL;
                end
            end
            WRITEBACK: begin
                stall       = 1'b1;
                mem_wr_en   = 1'b1;
                mem_addr    = {line_tag, req_index, {OFFSET_W{1'b0}}};
                mem_wr_data = line_data;
                if (mem_ack) begin
                    state_n = FILL;
                end
            end
            FILL: begin
                stall     = 1'b1;
                mem_rd_en = 1'b1;
                mem_addr  = {req_tag, req_index, {OFFSET_W{1'b0}}};
                if (mem_ack) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                stall    = 1'b1;
                rd_valid = req_rd;
                wr_done  = !req_rd;
                state_n  = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            valid_q  <= '0;
            dirty_q  <= '0;
            hit_cnt  <= '0;
            miss_cnt <= '0;
            rd_data  <= '0;
        end else begin
            state <= state_n;
            unique case (state)
                COMPARE: begin
                    if (line_hit) begin
                        if (hit_cnt != {CNT_W{1'b1}}) begin
                            hit_cnt <= hit_cnt + CNT_W'(1);
                        end
                        if (req_rd) begin
                            rd_data <= line_data;
                        end else begin
                            dirty_q[req_index] <= 1'b1;
                        end
                    end else if (miss_cnt != {CNT_W{1'b1}}) begin
                        miss_cnt <= miss_cnt + CNT_W'(1);
                    end
                end
                WRITEBACK: begin
                    if (mem_ack) begin
                        dirty_q[req_index] <= 1'b0;
                    end
                end
                FILL: begin
                    if (mem_ack) begin
                        valid_q[req_index] <= 1'b1;
                        dirty_q[req_index] <= !req_rd;
                        if (req_rd) begin
                            rd_data <= mem_rd_data;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Request latch and line storage carry no reset; only control state does.
    always_ff @(posedge clk) begin
        if (state == IDLE && (rd_en || wr_en)) begin
            req_rd    <= rd_en;
            req_tag   <= addr[ADDR_W-1 -: TAG_W];
            req_index <= addr[OFFSET_W +: INDEX_W];
            req_wdata <= wr_data;
            req_be    <= wr_be;
        end
        if (rst) begin
            if (state == COMPARE && line_hit && !req_rd) begin
                data_arr[req_index] <= merge_be(line_data, req_wdata, req_be);
            end
            if (state == FILL && mem_ack) begin
                tag_arr[req_index] <= req_tag;
                if (req_rd) begin
                    data_arr[req_index] <= mem_rd_data;
                end else begin
                    data_arr[req_index] <= merge_be(mem_rd_data, req_wdata, req_be);
                end
            end
        end
    end

endmodule

// File: tb/tb_cache_ctrl_wb.sv
// Bench for cache_ctrl_wb: vector table driven through a memory
// responder, with a read-data scoreboard and a 2-bit-counter twin.
module tb_cache_ctrl_wb;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] addr;
    logic [63:0] wr_data;
    logic [7:0]  wr_be;
    logic [63:0] mem_rd_data;
    logic        mem_ack;

    logic [63:0] rd_data;
    logic        rd_valid, wr_done, hit, stall;
    logic        mem_rd_en, mem_wr_en;
    logic [31:0] mem_addr;
    logic [63:0] mem_wr_data;
    logic [15:0] hit_cnt, miss_cnt;

    logic [63:0] d2_rd_data;
    logic        d2_rd_valid, d2_wr_done, d2_hit, d2_stall;
    logic        d2_mem_rd_en, d2_mem_wr_en;
    logic [31:0] d2_mem_addr;
    logic [63:0] d2_mem_wr_data;
    logic [1:0]  d2_hit_cnt, d2_miss_cnt;

    int checks = 0;
    int errors = 0;
    int exp_hits = 0;
    int exp_miss = 0;
    logic [63:0] rd_q[$];
    logic [63:0] mon_exp;

    always #5 clk = ~clk;

    cache_ctrl_wb #(.ADDR_W(32), .DATA_W(64), .INDEX_W(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .addr(addr),
        .wr_data(wr_data), .wr_be(wr_be), .rd_data(rd_data),
        .rd_valid(rd_valid), .wr_done(wr_done), .hit(hit), .stall(stall),
        .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
        .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data),
        .mem_ack(mem_ack), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    cache_ctrl_wb #(.ADDR_W(32), .DATA_W(64), .INDEX_W(4), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .addr(addr),
        .wr_data(wr_data), .wr_be(wr_be), .rd_data(d2_rd_data),
        .rd_valid(d2_rd_valid), .wr_done(d2_wr_done), .hit(d2_hit),
        .stall(d2_stall), .mem_rd_en(d2_mem_rd_en),
        .mem_wr_en(d2_mem_wr_en), .mem_addr(d2_mem_addr),
        .mem_wr_data(d2_mem_wr_data), .mem_rd_data(mem_rd_data),
        .mem_ack(mem_ack), .hit_cnt(d2_hit_cnt), .miss_cnt(d2_miss_cnt)
    );

    typedef struct {
        bit          rd;
        bit          wr;
        logic [31:0] addr;
        logic [63:0] wdata;
        logic [7:0]  be;
        bit          exp_hit;
        bit          exp_wb;
        logic [31:0] wb_addr;
        logic [63:0] wb_data;
        logic [63:0] fill;
        int          lat;
        logic [63:0] exp_rd;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp,
                     $time);
        end
    endtask

    function automatic vec_t mk(
        input bit rd, input bit wr, input logic [31:0] a,
        input logic [63:0] wd, input logic [7:0] be, input bit eh,
        input bit ewb, input logic [31:0] wba, input logic [63:0] wbd,
        input logic [63:0] fill, input int lat, input logic [63:0] erd
    );
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = a; v.wdata = wd; v.be = be;
        v.exp_hit = eh; v.exp_wb = ewb; v.wb_addr = wba; v.wb_data = wbd;
        v.fill = fill; v.lat = lat; v.exp_rd = erd;
        return v;
    endfunction

    function automatic logic [63:0] sat2(input int n);
        return (n > 3) ? 64'd3 : 64'(n);
    endfunction

    task automatic chk_counters();
        chk("hit_cnt", 64'(hit_cnt), 64'(exp_hits));
        chk("miss_cnt", 64'(miss_cnt), 64'(exp_miss));
        chk("sat_hit_cnt", 64'(d2_hit_cnt), sat2(exp_hits));
        chk("sat_miss_cnt", 64'(d2_miss_cnt), sat2(exp_miss));
    endtask

    always @(negedge clk) begin
        if (rd_valid && wr_done) begin
            chk("rd_valid_and_wr_done", 64'(wr_done), 64'd0);
        end
        if (mem_rd_en && mem_wr_en) begin
            chk("mem_both_enables", 64'(mem_wr_en), 64'd0);
        end
        if (rd_valid) begin
            if (rd_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_valid_unexpected: got %h expected none",
                         rd_data);
            end else begin
                mon_exp = rd_q.pop_front();
                chk("rd_data", rd_data, mon_exp);
            end
        end
    end

    task automatic run_txn(input vec_t v);
        int  cyc;
        int  n;
        int  phase;
        bit  fin;
        bit  saw_wb;
        bit  saw_fill;
        @(negedge clk);
        rd_en   = v.rd;
        wr_en   = v.wr;
        addr    = v.addr;
        wr_data = v.wdata;
        wr_be   = v.be;
        if (v.rd) rd_q.push_back(v.exp_rd);
        @(negedge clk);
        rd_en = 1'b0;
        wr_en = 1'b0;
        chk("stall_compare", 64'(stall), 64'd1);
        chk("hit", 64'(hit), 64'(v.exp_hit));
        if (v.exp_hit) exp_hits++;
        else exp_miss++;
        cyc = 0; n = 0; phase = 0;
        fin = 0; saw_wb = 0; saw_fill = 0;
        while (!fin && cyc < 60) begin
            @(negedge clk);
            cyc++;
            mem_ack = 1'b0;
            if (rd_valid || wr_done) begin
                fin = 1;
                chk("stall_done", 64'(stall), 64'd1);
                chk("rd_valid_kind", 64'(rd_valid), 64'(v.rd));
                chk("wr_done_kind", 64'(wr_done), 64'(v.wr && !v.rd));
            end else if (mem_wr_en) begin
                if (phase != 1) begin
                    phase = 1; n = 0; saw_wb = 1;
                    chk("wb_addr", 64'(mem_addr), 64'(v.wb_addr));
                    chk("wb_data", mem_wr_data, v.wb_data);
                end
                n++;
                if (n >= v.lat) mem_ack = 1'b1;
            end else if (mem_rd_en) begin
                if (phase != 2) begin
                    phase = 2; n = 0; saw_fill = 1;
                    chk("fill_addr", 64'(mem_addr),
                        64'({v.addr[31:3], 3'b000}));
                end
                n++;
                if (n >= v.lat) begin
                    mem_ack = 1'b1;
                    mem_rd_data = v.fill;
                end
            end
        end
        mem_ack = 1'b0;
        chk("txn_done", 64'(fin), 64'd1);
        chk("saw_wb", 64'(saw_wb), 64'(v.exp_wb));
        chk("saw_fill", 64'(saw_fill), 64'(!v.exp_hit));
        if (v.exp_hit) chk("hit_latency", 64'(cyc), 64'd1);
        @(negedge clk);
        chk("stall_idle", 64'(stall), 64'd0);
        chk_counters();
    endtask

    initial begin
        rst = 1'b0; rd_en = 1'b0; wr_en = 1'b0; addr = '0;
        wr_data = '0; wr_be = '0; mem_rd_data = '0; mem_ack = 1'b0;

        vecs[0]  = mk(1, 0, 32'h40, 0, 8'h00, 0, 0, 0, 0,
                      64'h1122334455667788, 3, 64'h1122334455667788);
        vecs[1]  = mk(1, 0, 32'h40, 0, 8'h00, 1, 0, 0, 0,
                      0, 1, 64'h1122334455667788);
        vecs[2]  = mk(0, 1, 32'h40, 64'hFFFFFFFF_AAAAAAAA, 8'h0F, 1, 0,
                      0, 0, 0, 1, 0);
        vecs[3]  = mk(1, 0, 32'h40, 0, 8'h00, 1, 0, 0, 0,
                      0, 1, 64'h11223344_AAAAAAAA);
        vecs[4]  = mk(1, 0, 32'hC0, 0, 8'h00, 0, 1, 32'h40,
                      64'h11223344_AAAAAAAA, 64'hC0C0_0000_0000_C0C0, 2,
                      64'hC0C0_0000_0000_C0C0);
        vecs[5]  = mk(0, 1, 32'h100, 64'h55, 8'h01, 0, 0, 0, 0,
                      64'h0, 1, 0);
        vecs[6]  = mk(1, 0, 32'h100, 0, 8'h00, 1, 0, 0, 0,
                      0, 1, 64'h55);
        vecs[7]  = mk(1, 0, 32'h180, 0, 8'h00, 0, 1, 32'h100, 64'h55,
                      64'hDEAD, 1, 64'hDEAD);
        vecs[8]  = mk(0, 1, 32'h48, 64'h0123456789ABCDEF, 8'hFF, 0, 0,
                      0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0);
        vecs[9]  = mk(0, 1, 32'h48, 64'hAB00_0000_0000_0000, 8'h80, 1, 0,
                      0, 0, 0, 1, 0);
        vecs[10] = mk(1, 0, 32'h4D, 0, 8'h00, 1, 0, 0, 0,
                      0, 1, 64'hAB23456789ABCDEF);
        vecs[11] = mk(1, 1, 32'h48, 64'h0, 8'hFF, 1, 0, 0, 0,
                      0, 1, 64'hAB23456789ABCDEF);
        vecs[12] = mk(1, 0, 32'h48, 0, 8'h00, 1, 0, 0, 0,
                      0, 1, 64'hAB23456789ABCDEF);

        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_rd_data", rd_data, 64'd0);
        chk("rst_rd_valid", 64'(rd_valid), 64'd0);
        chk("rst_wr_done", 64'(wr_done), 64'd0);
        chk("rst_stall", 64'(stall), 64'd0);
        chk("rst_hit", 64'(hit), 64'd0);
        chk("rst_mem_en", 64'({mem_rd_en, mem_wr_en}), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_mem_wr_data", mem_wr_data, 64'd0);
        chk_counters();

        for (int i = 0; i < 13; i++) begin
            run_txn(vecs[i]);
        end

        // Abort a fill with reset; the line must stay invalid.
        @(negedge clk);
        rd_en = 1'b1;
        addr  = 32'h40;
        @(negedge clk);
        rd_en = 1'b0;
        @(negedge clk);
        chk("abort_fill_active", 64'(mem_rd_en), 64'd1);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_mem_rd_en", 64'(mem_rd_en), 64'd0);
        chk("abort_stall", 64'(stall), 64'd0);
        chk("abort_rd_data", rd_data, 64'd0);
        exp_hits = 0;
        exp_miss = 0;
        chk_counters();
        rst = 1'b1;
        run_txn(mk(1, 0, 32'h40, 0, 8'h00, 0, 0, 0, 0,
                   64'h1122334455667788, 1, 64'h1122334455667788));
        run_txn(mk(1, 0, 32'hC0, 0, 8'h00, 0, 0, 0, 0,
                   64'h0BAD_F00D, 2, 64'h0BAD_F00D));

        repeat (3) @(negedge clk);
        chk("rd_q_empty", 64'(rd_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
